bp_resolve_ctrl: RTL and testbench

Sequencing controller for the tournament branch predictor. Tracks every predicted branch from fetch to execute in a small in-order queue, matches execute-stage resolutions against the oldest entry, and issues exactly one update command per resolved branch to the predictor with a valid/ready handshake. On a mispredict it raises a flush pulse and runs a short recovery sequence that clears all younger in-flight predictions and holds off fetch.

---
 rtl/bp_ctrl_pkg.sv | 16 +
 rtl/bp_inflight_fifo.sv | 62 ++++++
 rtl/bp_resolve_ctrl.sv | 140 ++++++++++++++
 tb/tb_bp_resolve_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_ctrl_pkg.sv
// rtl/bp_ctrl_pkg.sv - shared types for the branch predictor resolve controller
package bp_ctrl_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic        pred_local;
        logic        pred_global;
    } bp_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bp_ctrl_state_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// rtl/bp_inflight_fifo.sv - in-order queue of in-flight predicted branches
module bp_inflight_fifo
    import bp_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clear,
    input  logic      push,
    input  bp_entry_t push_entry,
    input  logic      pop,
    output bp_entry_t head,
    output logic      empty,
    output logic      full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    bp_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Entry storage; a stale slot is never observed because reads are gated by count.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_resolve_ctrl.sv
// rtl/bp_resolve_ctrl.sv - matches branch resolutions to predictions and issues predictor updates
module bp_resolve_ctrl
    import bp_ctrl_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_br_valid,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_pred_taken,
    input  logic        fetch_pred_local,
    input  logic        fetch_pred_global,
    output logic        fetch_stall,
    input  logic        ex_br_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_br_en,
    output logic        ex_stall,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [31:0] upd_pc,
    output logic        upd_br_en,
    output logic        upd_pred_local,
    output logic        upd_pred_global,
    output logic        mispredict,
    output logic        pc_mismatch
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYCLES - 1);

    bp_ctrl_state_t  state_q, state_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;

    bp_entry_t push_entry;
    bp_entry_t head;
    logic      fifo_empty;
    logic      fifo_full;
    logic      fifo_clear;
    logic      push;
    logic      resolve_acc;
    logic      hit;
    logic      miss;
    logic      pred_wrong;

    assign push_entry = '{pc: fetch_pc, pred_taken: fetch_pred_taken,
                          pred_local: fetch_pred_local, pred_global: fetch_pred_global};

    assign ex_stall    = upd_valid && !upd_ready;
    assign resolve_acc = ex_br_valid && !ex_stall;
    assign hit         = resolve_acc && (state_q == RUN) && !fifo_empty && (ex_pc == head.pc);
    assign miss        = resolve_acc && !hit;
    assign pred_wrong  = hit && (ex_br_en != head.pred_taken);
    assign fetch_stall = (fifo_full && !hit) || (state_q == FLUSH);
    assign push        = fetch_br_valid && !fetch_stall;

    bp_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (fifo_clear),
        .push       (push),
        .push_entry (push_entry),
        .pop        (hit),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    // Recovery state register and hold-off counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state: any bad resolution starts (or restarts) the hold-off and wipes the queue.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        fifo_clear  = 1'b0;
        case (state_q)
            RUN: begin
                if (pred_wrong || miss) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                    fifo_clear  = 1'b1;
                end
            end
            FLUSH: begin
                if (miss) begin
                    flush_cnt_d = '0;
                    fifo_clear  = 1'b1;
                end else if (flush_cnt_q == FC_LAST) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FC_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Update command register; a new load may replace a command accepted this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid       <= 1'b0;
            upd_pc          <= '0;
            upd_br_en       <= 1'b0;
            upd_pred_local  <= 1'b0;
            upd_pred_global <= 1'b0;
        end else if (hit) begin
            upd_valid       <= 1'b1;
            upd_pc          <= head.pc;
            upd_br_en       <= ex_br_en;
            upd_pred_local  <= head.pred_local;
            upd_pred_global <= head.pred_global;
        end else if (upd_valid && upd_ready) begin
            upd_valid <= 1'b0;
        end
    end

    // Registered one-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispredict  <= 1'b0;
            pc_mismatch <= 1'b0;
        end else begin
            mispredict  <= pred_wrong;
            pc_mismatch <= miss;
        end
    end

endmodule

// File: tb/tb_bp_resolve_ctrl.sv
// tb/tb_bp_resolve_ctrl.sv - directed self-checking bench for bp_resolve_ctrl
module tb_bp_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_br_valid;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
    logic        fetch_pred_local;
    logic        fetch_pred_global;
    logic        fetch_stall;
    logic        ex_br_valid;
    logic [31:0] ex_pc;
    logic        ex_br_en;
    logic        ex_stall;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic        upd_br_en;
    logic        upd_pred_local;
    logic        upd_pred_global;
    logic        mispredict;
    logic        pc_mismatch;

    int checks = 0;
    int errors = 0;

    bp_resolve_ctrl #(
        .DEPTH        (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .fetch_br_valid    (fetch_br_valid),
        .fetch_pc          (fetch_pc),
        .fetch_pred_taken  (fetch_pred_taken),
        .fetch_pred_local  (fetch_pred_local),
        .fetch_pred_global (fetch_pred_global),
        .fetch_stall       (fetch_stall),
        .ex_br_valid       (ex_br_valid),
        .ex_pc             (ex_pc),
        .ex_br_en          (ex_br_en),
        .ex_stall          (ex_stall),
        .upd_valid         (upd_valid),
        .upd_ready         (upd_ready),
        .upd_pc            (upd_pc),
        .upd_br_en         (upd_br_en),
        .upd_pred_local    (upd_pred_local),
        .upd_pred_global   (upd_pred_global),
        .mispredict        (mispredict),
        .pc_mismatch       (pc_mismatch)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_br_valid    = 1'b0;
        fetch_pc          = '0;
        fetch_pred_taken  = 1'b0;
        fetch_pred_local  = 1'b0;
        fetch_pred_global = 1'b0;
        ex_br_valid       = 1'b0;
        ex_pc             = '0;
        ex_br_en          = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic t, input logic l, input logic g);
        fetch_br_valid = 1'b1; fetch_pc = pc;
        fetch_pred_taken = t; fetch_pred_local = l; fetch_pred_global = g;
        tick();
        fetch_br_valid = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic en);
        ex_br_valid = 1'b1; ex_pc = pc; ex_br_en = en;
        tick();
        ex_br_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; idle(); upd_ready = 1'b1;
        tick(); tick();
        checks++; if ({upd_valid, upd_pc, upd_br_en, upd_pred_local, upd_pred_global} !== 36'h0) begin errors++; $display("FAIL reset_upd: got %b/%h exp 0", upd_valid, upd_pc); end
        checks++; if ({mispredict, pc_mismatch, fetch_stall, ex_stall} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {mispredict, pc_mismatch, fetch_stall, ex_stall}); end
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        push(32'h100, 1'b1, 1'b1, 1'b0);
        push(32'h104, 1'b0, 1'b0, 1'b1);
        push(32'h108, 1'b1, 1'b1, 1'b1);
        resolve(32'h100, 1'b1);
        checks++; if ({upd_valid, upd_pc, upd_br_en, upd_pred_local, upd_pred_global} !== {1'b1, 32'h100, 3'b110}) begin errors++; $display("FAIL inorder_upd0: got %b %h %b%b%b exp 1 100 110", upd_valid, upd_pc, upd_br_en, upd_pred_local, upd_pred_global); end
        checks++; if (mispredict !== 1'b0 || pc_mismatch !== 1'b0) begin errors++; $display("FAIL inorder_flags0: got %b%b exp 00", mispredict, pc_mismatch); end
        resolve(32'h104, 1'b0);
        checks++; if ({upd_valid, upd_pc, upd_br_en, upd_pred_local, upd_pred_global} !== {1'b1, 32'h104, 3'b001}) begin errors++; $display("FAIL inorder_upd1: got %b %h %b%b%b exp 1 104 001", upd_valid, upd_pc, upd_br_en, upd_pred_local, upd_pred_global); end
        resolve(32'h108, 1'b1);
        checks++; if ({upd_valid, upd_pc, upd_br_en, upd_pred_local, upd_pred_global} !== {1'b1, 32'h108, 3'b111}) begin errors++; $display("FAIL inorder_upd2: got %b %h %b%b%b exp 1 108 111", upd_valid, upd_pc, upd_br_en, upd_pred_local, upd_pred_global); end
        checks++; if (mispredict !== 1'b0 || pc_mismatch !== 1'b0) begin errors++; $display("FAIL inorder_flags2: got %b%b exp 00", mispredict, pc_mismatch); end
        tick();
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL inorder_drop: got upd_valid %b exp 0", upd_valid); end
    endtask

    task automatic test_full();
        push(32'h10, 1'b0, 1'b0, 1'b0);
        push(32'h14, 1'b0, 1'b0, 1'b0);
        push(32'h18, 1'b0, 1'b0, 1'b0);
        push(32'h1C, 1'b0, 1'b0, 1'b0);
        fetch_br_valid = 1'b1; fetch_pc = 32'h20;
        #1;
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b exp 1", fetch_stall); end
        ex_br_valid = 1'b1; ex_pc = 32'h10; ex_br_en = 1'b0;
        #1;
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL full_pushpop_stall: got %b exp 0", fetch_stall); end
        tick();
        fetch_br_valid = 1'b0; ex_br_valid = 1'b0;
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h10) begin errors++; $display("FAIL full_pop_upd: got %b %h exp 1 10", upd_valid, upd_pc); end
        fetch_br_valid = 1'b1; fetch_pc = 32'h24;
        #1;
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL full_still_full: got %b exp 1", fetch_stall); end
        fetch_br_valid = 1'b0;
        resolve(32'h14, 1'b0);
        resolve(32'h18, 1'b0);
        resolve(32'h1C, 1'b0);
        checks++; if (upd_pc !== 32'h1C || pc_mismatch !== 1'b0) begin errors++; $display("FAIL full_drain3: got %h %b exp 1c 0", upd_pc, pc_mismatch); end
        resolve(32'h20, 1'b0);
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h20 || pc_mismatch !== 1'b0 || mispredict !== 1'b0) begin errors++; $display("FAIL full_fifth: got %b %h %b%b exp 1 20 00", upd_valid, upd_pc, pc_mismatch, mispredict); end
        tick();
    endtask

    task automatic test_mispredict();
        push(32'h200, 1'b1, 1'b0, 1'b1);
        resolve(32'h200, 1'b0);
        checks++; if (mispredict !== 1'b1 || pc_mismatch !== 1'b0) begin errors++; $display("FAIL mp_pulse: got %b%b exp 10", mispredict, pc_mismatch); end
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h200 || upd_br_en !== 1'b0) begin errors++; $display("FAIL mp_upd: got %b %h %b exp 1 200 0", upd_valid, upd_pc, upd_br_en); end
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL mp_stall1: got %b exp 1", fetch_stall); end
        fetch_br_valid = 1'b1; fetch_pc = 32'h204; fetch_pred_taken = 1'b0;
        tick();
        checks++; if (mispredict !== 1'b0 || fetch_stall !== 1'b1) begin errors++; $display("FAIL mp_stall2: got mp %b stall %b exp 0 1", mispredict, fetch_stall); end
        tick();
        fetch_br_valid = 1'b0;
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL mp_release: got %b exp 0", fetch_stall); end
        resolve(32'h204, 1'b0);
        checks++; if (pc_mismatch !== 1'b1 || upd_valid !== 1'b0) begin errors++; $display("FAIL mp_queue_empty: got pcm %b upd %b exp 1 0", pc_mismatch, upd_valid); end
        tick(); tick();
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL mp_recover: got %b exp 0", fetch_stall); end
    endtask

    task automatic test_backpressure();
        push(32'h400, 1'b1, 1'b1, 1'b0);
        push(32'h404, 1'b0, 1'b0, 1'b1);
        upd_ready = 1'b0;
        resolve(32'h400, 1'b1);
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h400 || ex_stall !== 1'b1) begin errors++; $display("FAIL bp_first: got %b %h stall %b exp 1 400 1", upd_valid, upd_pc, ex_stall); end
        ex_br_valid = 1'b1; ex_pc = 32'h404; ex_br_en = 1'b0;
        tick(); tick();
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h400 || upd_br_en !== 1'b1 || upd_pred_local !== 1'b1 || pc_mismatch !== 1'b0) begin errors++; $display("FAIL bp_hold: got %b %h %b%b pcm %b exp 1 400 11 0", upd_valid, upd_pc, upd_br_en, upd_pred_local, pc_mismatch); end
        upd_ready = 1'b1;
        #1;
        checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL bp_unstall: got %b exp 0", ex_stall); end
        tick();
        ex_br_valid = 1'b0;
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h404 || upd_pred_global !== 1'b1 || mispredict !== 1'b0) begin errors++; $display("FAIL bp_second: got %b %h %b mp %b exp 1 404 1 0", upd_valid, upd_pc, upd_pred_global, mispredict); end
        tick();
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b exp 0", upd_valid); end
    endtask

    task automatic test_pc_mismatch();
        resolve(32'h500, 1'b1);
        checks++; if (pc_mismatch !== 1'b1 || upd_valid !== 1'b0 || mispredict !== 1'b0 || fetch_stall !== 1'b1) begin errors++; $display("FAIL pcm_empty: got pcm %b upd %b mp %b stall %b exp 1 0 0 1", pc_mismatch, upd_valid, mispredict, fetch_stall); end
        tick();
        checks++; if (pc_mismatch !== 1'b0) begin errors++; $display("FAIL pcm_pulse: got %b exp 0", pc_mismatch); end
        tick();
        push(32'h304, 1'b0, 1'b0, 1'b0);
        resolve(32'h300, 1'b0);
        checks++; if (pc_mismatch !== 1'b1 || upd_valid !== 1'b0 || fetch_stall !== 1'b1) begin errors++; $display("FAIL pcm_pc: got pcm %b upd %b stall %b exp 1 0 1", pc_mismatch, upd_valid, fetch_stall); end
        resolve(32'h304, 1'b0);
        checks++; if (pc_mismatch !== 1'b1 || upd_valid !== 1'b0) begin errors++; $display("FAIL pcm_in_flush: got pcm %b upd %b exp 1 0", pc_mismatch, upd_valid); end
        tick();
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL pcm_restart: got %b exp 1", fetch_stall); end
        tick();
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL pcm_release: got %b exp 0", fetch_stall); end
    endtask

    task automatic test_reset_flush();
        push(32'h600, 1'b1, 1'b1, 1'b1);
        upd_ready = 1'b0;
        resolve(32'h600, 1'b0);
        checks++; if (mispredict !== 1'b1 || upd_valid !== 1'b1 || fetch_stall !== 1'b1 || ex_stall !== 1'b1) begin errors++; $display("FAIL rf_setup: got %b%b%b%b exp 1111", mispredict, upd_valid, fetch_stall, ex_stall); end
        #1 rst = 1'b0;
        #1;
        checks++; if ({upd_valid, upd_pc, upd_br_en, upd_pred_local, upd_pred_global, mispredict, pc_mismatch, fetch_stall, ex_stall} !== 40'h0) begin errors++; $display("FAIL rf_async: got %b %h %b%b%b%b exp all 0", upd_valid, upd_pc, mispredict, pc_mismatch, fetch_stall, ex_stall); end
        tick();
        #1 rst = 1'b1;
        upd_ready = 1'b1;
        tick();
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL rf_run: got %b exp 0", fetch_stall); end
        push(32'h700, 1'b0, 1'b0, 1'b0);
        resolve(32'h700, 1'b0);
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h700 || pc_mismatch !== 1'b0) begin errors++; $display("FAIL rf_after: got %b %h %b exp 1 700 0", upd_valid, upd_pc, pc_mismatch); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_mispredict();
        test_backpressure();
        test_pc_mismatch();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
